// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - opcode-driven microcode sequencer with a runtime-writable table
module micro_sequencer #(
    parameter int OPC_W     = 2,
    parameter int SIG_W     = 8,
    parameter int STEP_W    = 2,
    parameter bit HOLD_IDLE = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_instr_valid,
    output logic                    o_instr_ready,
    input  logic [OPC_W-1:0]        i_instr,
    input  logic                    i_cfg_we,
    input  logic [OPC_W+STEP_W-1:0] i_cfg_addr,
    input  logic [SIG_W:0]          i_cfg_data,
    output logic [SIG_W-1:0]        o_signal,
    output logic                    o_sig_valid,
    output logic                    o_done,
    output logic                    o_busy
);

    localparam int DEPTH = 2 ** (OPC_W + STEP_W);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              r_state;
    logic [STEP_W-1:0]   r_step;
    logic [OPC_W-1:0]    r_opc;
    logic [SIG_W-1:0]    r_signal;
    logic                r_sig_valid;
    logic                r_done;
    logic [SIG_W:0]      r_tbl [DEPTH];

    logic                w_accept;
    logic [STEP_W-1:0]   w_step_inc;
    logic [SIG_W:0]      w_first_entry;
    logic [SIG_W:0]      w_next_entry;

    // A new opcode can be taken when idle or on the last word of the current sequence
    assign o_instr_ready = (r_state == S_IDLE) || (r_state == S_RUN && r_done);
    assign w_accept      = i_instr_valid && o_instr_ready;
    assign w_step_inc    = r_step + 1'b1;
    // Combinational reads: a same-edge write is not yet visible, so reads see old contents
    assign w_first_entry = r_tbl[{i_instr, {STEP_W{1'b0}}}];
    assign w_next_entry  = r_tbl[{r_opc, w_step_inc}];

    assign o_signal    = r_signal;
    assign o_sig_valid = r_sig_valid;
    assign o_done      = r_done;
    assign o_busy      = (r_state == S_RUN);

    // Microcode table: reset to single-word zero sequences, written one entry per strobe
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tbl[i] <= {1'b1, {SIG_W{1'b0}}};
            end
        end else if (i_cfg_we) begin
            r_tbl[i_cfg_addr] <= i_cfg_data;
        end
    end

    // Sequencer FSM: start on accept, step until LAST or the final step index, then idle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_step      <= '0;
            r_opc       <= '0;
            r_signal    <= '0;
            r_sig_valid <= 1'b0;
            r_done      <= 1'b0;
        end else if (w_accept) begin
            r_state     <= S_RUN;
            r_step      <= '0;
            r_opc       <= i_instr;
            r_signal    <= w_first_entry[SIG_W-1:0];
            r_sig_valid <= 1'b1;
            r_done      <= w_first_entry[SIG_W];
        end else if (r_state == S_RUN && !r_done) begin
            r_step      <= w_step_inc;
            r_signal    <= w_next_entry[SIG_W-1:0];
            // The last step index ends the sequence so the counter never wraps
            r_done      <= w_next_entry[SIG_W] || (w_step_inc == {STEP_W{1'b1}});
        end else if (r_state == S_RUN) begin
            r_state     <= S_IDLE;
            r_sig_valid <= 1'b0;
            r_done      <= 1'b0;
            if (!HOLD_IDLE) begin
                r_signal <= '0;
            end
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - scoreboard bench for micro_sequencer, both HOLD_IDLE settings
module tb_micro_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic [1:0] instr;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [8:0] cfg_data;

    logic       ready0, sig_valid0, done0, busy0;
    logic [7:0] sig0;
    logic       ready1, sig_valid1, done1, busy1;
    logic [7:0] sig1;

    typedef struct {
        logic [7:0] word;
        logic       done;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] hold_word;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    micro_sequencer #(.OPC_W(2), .SIG_W(8), .STEP_W(2), .HOLD_IDLE(1'b0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_instr_valid(instr_valid), .o_instr_ready(ready0),
        .i_instr(instr), .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
        .o_signal(sig0), .o_sig_valid(sig_valid0), .o_done(done0), .o_busy(busy0)
    );

    micro_sequencer #(.OPC_W(2), .SIG_W(8), .STEP_W(2), .HOLD_IDLE(1'b1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_instr_valid(instr_valid), .o_instr_ready(ready1),
        .i_instr(instr), .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
        .o_signal(sig1), .o_sig_valid(sig_valid1), .o_done(done1), .o_busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] word, input logic done);
        exp_t e;
        e.word = word;
        e.done = done;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        logic exp_active;
        @(posedge clk);
        #1;
        exp_active = (sb_q.size() != 0);
        chk("sig_valid0", sig_valid0, exp_active);
        chk("sig_valid1", sig_valid1, exp_active);
        chk("busy0", busy0, exp_active);
        chk("busy1", busy1, exp_active);
        if (exp_active) begin
            e = sb_q.pop_front();
            chk("signal0", sig0, e.word);
            chk("signal1", sig1, e.word);
            chk("done0", done0, e.done);
            chk("done1", done1, e.done);
            hold_word = e.word;
        end else begin
            chk("idle_signal0", sig0, 8'h00);
            chk("idle_signal_hold", sig1, hold_word);
            chk("idle_done0", done0, 1'b0);
            chk("idle_done1", done1, 1'b0);
        end
    endtask

    task automatic write(input logic [1:0] op, input logic [1:0] step, input logic [8:0] data);
        cfg_we   = 1'b1;
        cfg_addr = {op, step};
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = 2'd0;
        cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 9'd0;
        hold_word = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        chk("ready_after_reset", ready0, 1'b1);

        // Reset table: op 2 is a single zero word
        instr = 2'd2; instr_valid = 1'b1;
        push(8'h00, 1'b1);
        tick();
        instr_valid = 1'b0;
        tick();

        // Three-word op1 sequence, ready low on the first two words
        write(2'd1, 2'd0, 9'h06A);
        write(2'd1, 2'd1, 9'h024);
        write(2'd1, 2'd2, 9'h110);
        instr = 2'd1; instr_valid = 1'b1;
        push(8'h6A, 1'b0); push(8'h24, 1'b0); push(8'h10, 1'b1);
        tick();
        instr_valid = 1'b0;
        chk("ready_word0", ready0, 1'b0);
        tick();
        chk("ready_word1", ready0, 1'b0);
        tick();
        chk("ready_last", ready0, 1'b1);
        tick();

        // Four steps with no LAST: final index forces DONE, no wrap
        write(2'd0, 2'd0, 9'h001);
        write(2'd0, 2'd1, 9'h002);
        write(2'd0, 2'd2, 9'h003);
        write(2'd0, 2'd3, 9'h004);
        instr = 2'd0; instr_valid = 1'b1;
        push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h04, 1'b1);
        tick();
        instr_valid = 1'b0;
        tick(); tick(); tick();
        tick();
        tick();

        // Back-to-back op1 then op0 with valid held throughout
        write(2'd0, 2'd0, 9'h1C1);
        instr = 2'd1; instr_valid = 1'b1;
        push(8'h6A, 1'b0); push(8'h24, 1'b0); push(8'h10, 1'b1);
        tick();
        instr = 2'd0;
        tick();
        tick();
        chk("ready_b2b", ready0, 1'b1);
        push(8'hC1, 1'b1);
        tick();
        instr_valid = 1'b0;
        tick();

        // Write of {op1,1} on the edge that reads it: old word goes out
        instr = 2'd1; instr_valid = 1'b1;
        push(8'h6A, 1'b0); push(8'h24, 1'b0); push(8'h10, 1'b1);
        tick();
        instr_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = {2'd1, 2'd1}; cfg_data = 9'h0FF;
        tick();
        cfg_we = 1'b0;
        tick();
        tick();
        instr = 2'd1; instr_valid = 1'b1;
        push(8'h6A, 1'b0); push(8'hFF, 1'b0); push(8'h10, 1'b1);
        tick();
        instr_valid = 1'b0;
        tick(); tick();
        tick();

        // Reset mid-sequence clears state, outputs and table
        instr = 2'd1; instr_valid = 1'b1;
        push(8'h6A, 1'b0); push(8'hFF, 1'b0);
        tick();
        instr_valid = 1'b0;
        tick();
        rst = 1'b1;
        hold_word = 8'h00;
        tick();
        rst = 1'b0;
        chk("ready_post_rst", ready0, 1'b1);
        instr = 2'd1; instr_valid = 1'b1;
        push(8'h00, 1'b1);
        tick();
        instr_valid = 1'b0;
        tick();

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
